// File: rtl/bcd_display_pkg.sv
// Segment constants and BCD-to-segment helper shared by the display scanner.
// Active-high encoding, bit6..bit0 = g f e d c b a.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h67;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; non-BCD nibbles show a dash.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg(nibble_i);

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-segment scanner with frame-aligned value commit and leading-zero blanking.
// Define BCD_DISPLAY_DP_EN to add the per-digit decimal point (dp_mask in, dp_o out).
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  blank_lz,
`ifdef BCD_DISPLAY_DP_EN
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  dp_o,
`endif
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef BCD_DISPLAY_DP_EN
    localparam int unsigned SW = 5 * DIGITS;
`else
    localparam int unsigned SW = 4 * DIGITS;
`endif
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic          INV      = (ACTIVE_LOW != 0);

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    // Shadow words: BCD digits in the low 4*DIGITS bits, DP mask above when enabled.
    logic [SW-1:0]     pend_q, pend_d, disp_q, disp_d, load_word;
    logic              pend_full_q, pend_full_d;
    logic              tick, xfer, commit;
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] an_next;
    logic              lz_run, blank;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;

`ifdef BCD_DISPLAY_DP_EN
    logic cur_dp, dp_q;
    assign load_word = {dp_mask, load_value};
    assign dp_o      = dp_q;
`else
    assign load_word = load_value;
`endif

    assign load_ready = ~pend_full_q;
    assign seg_o      = seg_q;
    assign an_o       = an_q;

    always_comb begin
        tick   = (pcnt_q == PCNT_MAX);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        xfer        = load_valid && load_ready;
        commit      = tick && (idx_q == IDX_MAX) && pend_full_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        // Transfer and commit are exclusive: load_ready is low whenever a commit can fire.
        if (xfer) begin
            pend_d      = load_word;
            pend_full_d = 1'b1;
        end else if (commit) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
    end

    // Walk from the top digit down so lz_run holds "this digit and all above are zero".
    always_comb begin
        cur_digit = '0;
        an_next   = '0;
        lz_run    = 1'b1;
        blank     = 1'b0;
`ifdef BCD_DISPLAY_DP_EN
        cur_dp    = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run && (disp_q[4*k +: 4] == 4'd0);
            if (IW'(k) == idx_q) begin
                cur_digit  = disp_q[4*k +: 4];
                an_next[k] = 1'b1;
                blank      = blank_lz && (k != 0) && lz_run;
`ifdef BCD_DISPLAY_DP_EN
                cur_dp     = disp_q[4*DIGITS + k];
`endif
            end
        end
    end

    seg7_decode u_decode (
        .nibble_i (cur_digit),
        .seg_o    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            disp_q      <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= {7{INV}};
            an_q        <= {DIGITS{INV}};
`ifdef BCD_DISPLAY_DP_EN
            dp_q        <= INV;
`endif
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            disp_q      <= disp_d;
            pend_full_q <= pend_full_d;
            seg_q       <= (blank ? SEG_OFF : dec_seg) ^ {7{INV}};
            an_q        <= (blank ? '0 : an_next) ^ {DIGITS{INV}};
`ifdef BCD_DISPLAY_DP_EN
            dp_q        <= (blank ? 1'b0 : cur_dp) ^ INV;
`endif
        end
    end

endmodule
